// File: rtl/wb_port_arbiter.sv
// Purpose: share the regfile write port between the writeback stage and a buffered long-latency unit.
// Latency: the winning write appears on rf_* one cycle after it is issued; lu results wait in a DEPTH-entry FIFO.
// Backpressure: lu_ready = FIFO not full; a starved FIFO head raises wb_stall_req to request one pipeline bubble.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8,
  parameter int XLEN         = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            wbp_valid,
  input  logic [4:0]      wbp_dst,
  input  logic [XLEN-1:0] wbp_data,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  logic [4:0]      lu_dst,
  input  logic [XLEN-1:0] lu_data,
  output logic            rf_we,
  output logic [4:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic [31:0]     busy_mask,
  output logic            wb_stall_req
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  // Result buffer; entryKill marks results overwritten by a younger pipeline write.
  logic [4:0]      entryDst  [DEPTH];
  logic [XLEN-1:0] entryData [DEPTH];
  logic [DEPTH-1:0] entryKill;
  logic [PW-1:0]   headPtr, tailPtr;
  logic [PW:0]     count;
  logic [CW-1:0]   starveCnt, starveNext;
  logic            stallReq;

  logic [DEPTH-1:0] occupied, liveMask;
  logic             anyLive, headOcc, headKill, headLive;
  logic             pipeUse, luAccept, luKeep, fifoWrite, bypass, pop, push;
  logic             portWe;
  logic [4:0]       portWa;
  logic [XLEN-1:0]  portWd;
  logic [31:0]      busyMask;

  // Which slots hold entries, and which of those are still going to be written.
  always_comb begin
    occupied = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupied[i] = ({1'b0, PW'(PW'(i) - headPtr)} < count);
    end
    liveMask = occupied & ~entryKill;
    anyLive  = |liveMask;
    headOcc  = (count != '0);
    headKill = entryKill[headPtr];
    headLive = headOcc && !headKill;
  end

  // Port arbitration: pipeline, then live head, then same-cycle bypass into an empty-of-live FIFO.
  always_comb begin
    lu_ready  = (count != (PW+1)'(DEPTH));
    pipeUse   = wbp_valid && (wbp_dst != 5'd0);
    luAccept  = lu_valid && lu_ready;
    luKeep    = luAccept && (lu_dst != 5'd0) && !(pipeUse && (lu_dst == wbp_dst));
    fifoWrite = !pipeUse && headLive;
    bypass    = !pipeUse && !anyLive && luKeep;
    pop       = headOcc && (headKill || fifoWrite);
    push      = luKeep && !bypass;
    portWe    = pipeUse || fifoWrite || bypass;
    portWa    = lu_dst;
    portWd    = lu_data;
    if (pipeUse) begin
      portWa = wbp_dst;
      portWd = wbp_data;
    end else if (fifoWrite) begin
      portWa = entryDst[headPtr];
      portWd = entryData[headPtr];
    end
  end

  // Starvation count of a live head that keeps losing the port to the pipeline.
  always_comb begin
    starveNext = starveCnt;
    if (pop || !headOcc) begin
      starveNext = '0;
    end else if (headLive && pipeUse && (starveCnt != CW'(STARVE_LIMIT))) begin
      starveNext = starveCnt + CW'(1);
    end
  end

  // Registers that readers of xN must wait for.
  always_comb begin
    busyMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (liveMask[i]) busyMask[entryDst[i]] = 1'b1;
    end
  end

  assign busy_mask    = busyMask;
  assign wb_stall_req = stallReq;

  // Result payload storage; only the tail slot is written on a push.
  always_ff @(posedge clk) begin
    if (push) begin
      entryDst[tailPtr]  <= lu_dst;
      entryData[tailPtr] <= lu_data;
    end
  end

  // Kill bits: a pipeline write to the same register makes a buffered result stale.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entryKill <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (tailPtr == PW'(i))) begin
          entryKill[i] <= 1'b0;
        end else if (pipeUse && occupied[i] && (entryDst[i] == wbp_dst)) begin
          entryKill[i] <= 1'b1;
        end
      end
    end
  end

  // FIFO pointers, occupancy and the starvation state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      headPtr   <= '0;
      tailPtr   <= '0;
      count     <= '0;
      starveCnt <= '0;
      stallReq  <= 1'b0;
    end else begin
      if (pop)  headPtr <= headPtr + PW'(1);
      if (push) tailPtr <= tailPtr + PW'(1);
      if (push && !pop)      count <= count + (PW+1)'(1);
      else if (pop && !push) count <= count - (PW+1)'(1);
      starveCnt <= starveNext;
      stallReq  <= (starveNext == CW'(STARVE_LIMIT));
    end
  end

  // Registered regfile write; address and data hold when no write is issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= portWe;
      if (portWe) begin
        rf_wa <= portWa;
        rf_wd <= portWd;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model of the port rules.
module tb_wb_port_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wbp_valid = 1'b0;
  logic [4:0]  wbp_dst = '0;
  logic [63:0] wbp_data = '0;
  logic        lu_valid = 1'b0;
  logic        lu_ready;
  logic [4:0]  lu_dst = '0;
  logic [63:0] lu_data = '0;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [63:0] rf_wd;
  logic [31:0] busy_mask;
  logic        wb_stall_req;

  int testsRun = 0;
  int testsFailed = 0;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT), .XLEN(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .wbp_valid(wbp_valid), .wbp_dst(wbp_dst), .wbp_data(wbp_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_dst(lu_dst), .lu_data(lu_data),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .busy_mask(busy_mask), .wb_stall_req(wb_stall_req)
  );

  always #5 clk = ~clk;

  // Reference model: queue of buffered results in arrival order.
  typedef struct packed {
    logic [4:0]  dst;
    logic [63:0] data;
    logic        killed;
  } ent_t;

  ent_t        mq[$];
  int          mWait = 0;
  logic        mStall = 1'b0;
  logic        mWe = 1'b0;
  logic [4:0]  mWa = '0;
  logic [63:0] mWd = '0;
  logic        lastReady;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelBusy();
    logic [31:0] b = '0;
    foreach (mq[i]) if (!mq[i].killed) b[mq[i].dst] = 1'b1;
    return b;
  endfunction

  function automatic int liveCount();
    int n = 0;
    foreach (mq[i]) if (!mq[i].killed) n++;
    return n;
  endfunction

  task automatic modelReset();
    mq.delete();
    mWait = 0; mStall = 1'b0; mWe = 1'b0; mWa = '0; mWd = '0;
  endtask

  // One clock cycle: drive, check pre-edge outputs, advance model, check post-edge outputs.
  task automatic cycle(input logic v, input logic [4:0] d, input logic [63:0] dat,
                       input logic lv, input logic [4:0] ld, input logic [63:0] ldat);
    logic ready, pipe, keep, popped, headKilled;
    int preSize, live;
    wbp_valid = v; wbp_dst = d; wbp_data = dat;
    lu_valid = lv; lu_dst = ld; lu_data = ldat;
    #1;
    ready = (mq.size() < DEPTH);
    check("lu_ready", lu_ready, ready);
    check("busy_mask", busy_mask, modelBusy());
    lastReady = ready;

    pipe    = v && (d != 5'd0);
    keep    = lv && ready && (ld != 5'd0) && !(pipe && (ld == d));
    live    = liveCount();
    preSize = mq.size();
    headKilled = (preSize > 0) && mq[0].killed;
    popped  = 1'b0;
    mWe     = 1'b0;
    if (pipe) begin
      mWe = 1'b1; mWa = d; mWd = dat;
    end
    if (preSize > 0 && headKilled) begin
      void'(mq.pop_front());
      popped = 1'b1;
    end else if (preSize > 0 && !pipe) begin
      mWe = 1'b1; mWa = mq[0].dst; mWd = mq[0].data;
      void'(mq.pop_front());
      popped = 1'b1;
    end
    if (pipe) foreach (mq[i]) if (mq[i].dst == d) mq[i].killed = 1'b1;
    if (keep) begin
      if (!pipe && live == 0) begin
        mWe = 1'b1; mWa = ld; mWd = ldat;
      end else begin
        mq.push_back('{dst: ld, data: ldat, killed: 1'b0});
      end
    end
    if (popped || preSize == 0) mWait = 0;
    else if (mWait < LIMIT) mWait++;
    mStall = (mWait == LIMIT);

    @(posedge clk);
    #1;
    check("rf_we", rf_we, mWe);
    check("rf_wa", rf_wa, mWa);
    check("rf_wd", rf_wd, mWd);
    check("wb_stall_req", wb_stall_req, mStall);
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
  endtask

  initial begin
    logic        pv;
    logic [4:0]  pd;
    logic [63:0] pdat;
    logic        wv;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst rf_we", rf_we, 1'b0);
    check("rst rf_wa", rf_wa, 5'd0);
    check("rst rf_wd", rf_wd, 64'd0);
    check("rst busy", busy_mask, 32'd0);
    check("rst stall", wb_stall_req, 1'b0);
    check("rst lu_ready", lu_ready, 1'b1);
    reset_n = 1'b1;

    // Idle port: lu result bypasses straight to the regfile
    cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'hAA);
    check("bypass we", rf_we, 1'b1);
    check("bypass wa", rf_wa, 5'd5);
    check("bypass wd", rf_wd, 64'hAA);
    check("bypass busy", busy_mask, 32'd0);

    // Pipeline holds the port while two results fill the FIFO
    cycle(1'b1, 5'd3, 64'h11, 1'b1, 5'd7, 64'h22);
    cycle(1'b1, 5'd3, 64'h11, 1'b1, 5'd8, 64'h33);
    check("full lu_ready", lu_ready, 1'b0);
    check("full busy", busy_mask, 32'h180);
    cycle(1'b1, 5'd3, 64'h11, 1'b0, 5'd0, 64'd0);
    cycle(1'b1, 5'd3, 64'h11, 1'b0, 5'd0, 64'd0);
    check("pipe wa", rf_wa, 5'd3);
    idle();
    check("drain1 wa", rf_wa, 5'd7);
    check("drain1 wd", rf_wd, 64'h22);
    idle();
    check("drain2 wa", rf_wa, 5'd8);
    check("drain2 wd", rf_wd, 64'h33);

    // WAW: a pipeline write to x9 kills the buffered x9 result
    cycle(1'b1, 5'd3, 64'h11, 1'b1, 5'd9, 64'h99);
    check("waw busy set", busy_mask, 32'h200);
    cycle(1'b1, 5'd9, 64'h55, 1'b0, 5'd0, 64'd0);
    check("waw wd", rf_wd, 64'h55);
    check("waw busy clr", busy_mask, 32'd0);
    idle();
    check("killed pop no write", rf_we, 1'b0);

    // Same-cycle lu and pipeline to x4: lu result dropped
    cycle(1'b1, 5'd4, 64'h44, 1'b1, 5'd4, 64'h77);
    check("same wd", rf_wd, 64'h44);
    check("same busy", busy_mask, 32'd0);
    idle();
    check("same no write", rf_we, 1'b0);

    // Starvation: one buffered entry behind continuous pipeline writes
    cycle(1'b1, 5'd3, 64'h11, 1'b1, 5'd6, 64'h66);
    for (int k = 0; k < 7; k++) cycle(1'b1, 5'd3, 64'h11, 1'b0, 5'd0, 64'd0);
    check("starve pre", wb_stall_req, 1'b0);
    cycle(1'b1, 5'd3, 64'h11, 1'b0, 5'd0, 64'd0);
    check("starve set", wb_stall_req, 1'b1);
    cycle(1'b1, 5'd3, 64'h11, 1'b0, 5'd0, 64'd0);
    check("starve pipe wins", rf_wa, 5'd3);
    idle();
    check("starve drain wa", rf_wa, 5'd6);
    check("starve clr", wb_stall_req, 1'b0);

    // Reset while entries are buffered and a write is on the port
    cycle(1'b1, 5'd3, 64'h11, 1'b1, 5'd10, 64'hA0);
    cycle(1'b1, 5'd3, 64'h11, 1'b1, 5'd11, 64'hB0);
    check("pre-rst we", rf_we, 1'b1);
    reset_n = 1'b0;
    #1;
    modelReset();
    check("midrst we", rf_we, 1'b0);
    check("midrst wa", rf_wa, 5'd0);
    check("midrst wd", rf_wd, 64'd0);
    check("midrst busy", busy_mask, 32'd0);
    check("midrst lu_ready", lu_ready, 1'b1);
    check("midrst stall", wb_stall_req, 1'b0);
    wbp_valid = 1'b0; lu_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle();
    check("post-rst no write", rf_we, 1'b0);
    idle();

    // Random traffic; the producer holds an offer until it is accepted
    pv = 1'b0; pd = '0; pdat = '0;
    for (int n = 0; n < 600; n++) begin
      if (!pv && $urandom_range(0, 99) < 45) begin
        pv = 1'b1;
        pd = 5'($urandom_range(0, 7));
        pdat = {$urandom, $urandom};
      end
      wv = ($urandom_range(0, 99) < ((n < 350) ? 65 : 95));
      cycle(wv, 5'($urandom_range(0, 7)), {$urandom, $urandom}, pv, pd, pdat);
      if (pv && lastReady) pv = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single integer register-file write port between the in-order writeback stage and a long-latency unit (mul/div) that completes out of band.
- Pipeline writes always win the port. Long-latency results are held in a small FIFO and drain on idle port cycles.
- Stale buffered results are killed on write-after-write.
- A starvation counter requests a one-cycle pipeline bubble when a buffered result waits too long.
- Sits between the writeback stage / long-latency unit and the regfile.

Parameters:
- DEPTH, 2, long-latency result FIFO entries (power of two, >=2)
- STARVE_LIMIT, 8, cycles the FIFO head may wait before wb_stall_req asserts
- XLEN, 64, data width

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- wbp_valid  in  1  writeback stage has a register write this cycle
- wbp_dst  in  5  destination register of the pipeline write
- wbp_data  in  XLEN  data of the pipeline write
- lu_valid  in  1  long-latency unit offers a result
- lu_ready  out  1  arbiter accepts the result (= FIFO not full)
- lu_dst  in  5  destination register of the long-latency result
- lu_data  in  XLEN  data of the long-latency result
- rf_we  out  1  regfile write enable (registered)
- rf_wa  out  5  regfile write address (registered)
- rf_wd  out  XLEN  regfile write data (registered)
- busy_mask  out  32  bit i = a live FIFO entry targets xi (from registered state)
- wb_stall_req  out  1  request one pipeline bubble so the FIFO can drain (registered)

Behaviour:
- Reset (async, reset_n=0): FIFO empty, all kill bits clear, starve counter 0.
  - rf_we=0, rf_wa=0, rf_wd=0, wb_stall_req=0, busy_mask=0; lu_ready=1 once the FIFO is empty.
  - Reset mid-operation discards all buffered results.
- Port use:
  - Pipeline uses the port iff wbp_valid && wbp_dst!=0.
  - A pipeline write to x0 does not use the port.
- Write latency: the winning write issued at cycle t appears on rf_we/rf_wa/rf_wd at cycle t+1, for exactly one cycle.
  - rf_we=0 otherwise; rf_wa and rf_wd hold their last values.
- Source priority per cycle:
  1. Pipeline write.
  2. Live FIFO head.
  3. Bypass of an lu input accepted this cycle, only when the FIFO holds no live entry.
- Accept: an lu result is accepted when lu_valid && lu_ready.
  - Results with lu_dst=0 are accepted and discarded: no FIFO entry, no write.
  - An accepted result not bypassed is enqueued at the tail.
- Drain: when the port is not used by the pipeline, a live head is written and popped.
  - A killed head is popped without a write. The same cycle may also write the next live source per the priority list.
  - Killed entries are always popped, even when the pipeline holds the port.
- Ordering and WAW:
  - Long-latency results are older than any concurrent or later pipeline write.
  - A pipeline write to xd (d!=0) sets the kill bit of every live FIFO entry with dst d.
  - It also drops an lu input accepted the same cycle with lu_dst=d.
- Full FIFO: lu_ready=0; lu_valid is held by the producer until accepted.
  - A pop and a push in the same cycle while full are not allowed: lu_ready stays combinationally !full.
- busy_mask: OR of one-hot dst over live, unkilled FIFO entries.
  - Issue logic stalls readers of busy registers.
  - Pending writes already registered on rf_* are not included.
- Starvation counter:
  - Increments each cycle a live unkilled head exists and the pipeline holds the port.
  - Clears on head pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- wb_stall_req:
  - Asserts the cycle after the counter reaches STARVE_LIMIT.
  - Deasserts the cycle after the head pops.
  - If the pipeline still writes, the pipeline keeps priority.
- Pointer wrap: head and tail pointers are modulo DEPTH, plus a count register 0..DEPTH.

Test Plan:
- Reset, then lu_valid=1, lu_dst=5, lu_data=0xAA, wbp_valid=0 -> next cycle rf_we=1, rf_wa=5, rf_wd=0xAA; FIFO stays empty; busy_mask=0.
- wbp_valid=1 (dst=3, data=0x11) for 4 cycles; lu offers dst=7/0x22 then dst=8/0x33 -> pipeline writes x3 each cycle; lu_ready=0 after 2 accepts; busy_mask=0x180; on the first idle cycle rf_wa=7, then rf_wa=8.
- Buffered dst=9; pipeline writes dst=9 data=0x55 -> busy_mask bit9 clears; x9 is written only with 0x55; the killed entry pops with no write.
- Same-cycle lu dst=4 and pipeline dst=4 -> only the pipeline value is written; lu_ready=1 and the lu result is dropped.
- Pipeline writes continuously with 1 buffered entry -> wb_stall_req=1 after 8 waiting cycles; drop wbp_valid one cycle -> head written, wb_stall_req=0 the next cycle.
- Assert reset_n=0 with 2 entries buffered and rf_we=1 -> outputs immediately 0, busy_mask=0, lu_ready=1; after release nothing is written.
